timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_pkg.sv | 20 ++
 rtl/timer_channel.sv | 163 ++++++++++++++++
 rtl/timer_bank.sv | 106 ++++++++++
 tb/tb_timer_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and limits for the countdown timer bank.
// Optional feature macro used by the bank: TIMER_AUTO_RELOAD_EN.
package timer_pkg;

  localparam logic [1:0] SEL_SEC  = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_HOUR = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  function automatic logic hms_is_zero(input logic [5:0] sec,
                                       input logic [5:0] min,
                                       input logic [4:0] hour);
    return (sec == 6'd0) && (min == 6'd0) && (hour == 5'd0);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: hh:mm:ss value, done flag, borrow and edit logic.
// With TIMER_AUTO_RELOAD_EN a preset register reloads the value on expiry.
module timer_channel
  import timer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_tick,
  input  logic       i_edit_inc,
  input  logic       i_edit_dec,
  input  logic [1:0] i_field,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_done
);

  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hour;
  logic       r_done;

  logic [5:0] w_dec_sec;
  logic [5:0] w_dec_min;
  logic [4:0] w_dec_hour;
  logic       w_zero;
  logic       w_dec_zero;
  logic       w_active;

  logic [5:0] w_ed_sec;
  logic [5:0] w_ed_min;
  logic [4:0] w_ed_hour;
  logic       w_edit_any;

  // Borrow chain; only used when the value is nonzero, so hour never underflows.
  always_comb begin
    w_dec_sec  = r_sec - 6'd1;
    w_dec_min  = r_min;
    w_dec_hour = r_hour;
    if (r_sec == 6'd0) begin
      w_dec_sec = SEC_MAX;
      if (r_min == 6'd0) begin
        w_dec_min  = MIN_MAX;
        w_dec_hour = r_hour - 5'd1;
      end else begin
        w_dec_min = r_min - 6'd1;
      end
    end
  end

  assign w_zero     = hms_is_zero(r_sec, r_min, r_hour);
  assign w_dec_zero = hms_is_zero(w_dec_sec, w_dec_min, w_dec_hour);

  // Edits wrap within the selected field and never touch its neighbours.
  always_comb begin
    w_ed_sec   = r_sec;
    w_ed_min   = r_min;
    w_ed_hour  = r_hour;
    w_edit_any = (i_edit_inc | i_edit_dec) & (i_field != SEL_NONE);
    case (i_field)
      SEL_SEC: begin
        if (i_edit_inc)      w_ed_sec = (r_sec == SEC_MAX) ? 6'd0 : r_sec + 6'd1;
        else if (i_edit_dec) w_ed_sec = (r_sec == 6'd0) ? SEC_MAX : r_sec - 6'd1;
      end
      SEL_MIN: begin
        if (i_edit_inc)      w_ed_min = (r_min == MIN_MAX) ? 6'd0 : r_min + 6'd1;
        else if (i_edit_dec) w_ed_min = (r_min == 6'd0) ? MIN_MAX : r_min - 6'd1;
      end
      SEL_HOUR: begin
        if (i_edit_inc)      w_ed_hour = (r_hour == HOUR_MAX) ? 5'd0 : r_hour + 5'd1;
        else if (i_edit_dec) w_ed_hour = (r_hour == 5'd0) ? HOUR_MAX : r_hour - 5'd1;
      end
      default: ;
    endcase
  end

`ifdef TIMER_AUTO_RELOAD_EN
  logic [5:0] r_p_sec;
  logic [5:0] r_p_min;
  logic [4:0] r_p_hour;
  logic       w_preset_nz;

  assign w_preset_nz = ~hms_is_zero(r_p_sec, r_p_min, r_p_hour);
  // A nonzero preset keeps the channel counting through its one-cycle done pulse.
  assign w_active    = ~r_done | w_preset_nz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sec    <= '0;
      r_min    <= '0;
      r_hour   <= '0;
      r_done   <= 1'b0;
      r_p_sec  <= '0;
      r_p_min  <= '0;
      r_p_hour <= '0;
    end else if (!i_run) begin
      r_done <= 1'b0;
      if (w_edit_any) begin
        r_sec    <= w_ed_sec;
        r_min    <= w_ed_min;
        r_hour   <= w_ed_hour;
        r_p_sec  <= w_ed_sec;
        r_p_min  <= w_ed_min;
        r_p_hour <= w_ed_hour;
      end
    end else begin
      if (r_done && w_preset_nz) r_done <= 1'b0;
      if (w_active) begin
        if (w_zero || (i_tick && w_dec_zero)) begin
          r_done <= 1'b1;
          if (w_preset_nz) begin
            r_sec  <= r_p_sec;
            r_min  <= r_p_min;
            r_hour <= r_p_hour;
          end else begin
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
          end
        end else if (i_tick) begin
          r_sec  <= w_dec_sec;
          r_min  <= w_dec_min;
          r_hour <= w_dec_hour;
        end
      end
    end
  end
`else
  assign w_active = ~r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
      r_done <= 1'b0;
    end else if (!i_run) begin
      r_done <= 1'b0;
      if (w_edit_any) begin
        r_sec  <= w_ed_sec;
        r_min  <= w_ed_min;
        r_hour <= w_ed_hour;
      end
    end else if (w_active) begin
      if (w_zero) begin
        r_done <= 1'b1;
      end else if (i_tick) begin
        r_sec  <= w_dec_sec;
        r_min  <= w_dec_min;
        r_hour <= w_dec_hour;
        if (w_dec_zero) r_done <= 1'b1;
      end
    end
  end
`endif

  assign o_sec  = r_sec;
  assign o_min  = r_min;
  assign o_hour = r_hour;
  assign o_done = r_done;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH countdown timers sharing one free-running 1 s prescaler.
// Optional auto-reload per channel is enabled with TIMER_AUTO_RELOAD_EN.
module timer_bank
  import timer_pkg::*;
#(
  parameter  int CLK_FREQ_HZ = 1000,
  parameter  int N_CH        = 4,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] run,
  input  logic [CH_W-1:0] ch_sel,
  input  logic [1:0]      field_sel,
  input  logic            inc,
  input  logic            dec,
  output logic [5:0]      sec_out,
  output logic [5:0]      min_out,
  output logic [4:0]      hour_out,
  output logic [N_CH-1:0] done,
  output logic            tick
);

  localparam int             PW         = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_inc_prev;
  logic          r_dec_prev;

  logic          w_presc_wrap;
  logic          w_inc_rise;
  logic          w_dec_rise;
  logic          w_edit_inc;
  logic          w_edit_dec;

  logic [5:0]    w_ch_sec  [N_CH];
  logic [5:0]    w_ch_min  [N_CH];
  logic [4:0]    w_ch_hour [N_CH];

  // tick is registered, so it appears after the edge where the count wraps.
  assign w_presc_wrap = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
      r_tick  <= w_presc_wrap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inc_prev <= 1'b0;
      r_dec_prev <= 1'b0;
    end else begin
      r_inc_prev <= inc;
      r_dec_prev <= dec;
    end
  end

  assign w_inc_rise = inc & ~r_inc_prev;
  assign w_dec_rise = dec & ~r_dec_prev;
  // Coincident inc and dec edges cancel.
  assign w_edit_inc = w_inc_rise & ~w_dec_rise;
  assign w_edit_dec = w_dec_rise & ~w_inc_rise;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic w_sel;
    assign w_sel = (ch_sel == CH_W'(gi));

    timer_channel u_ch (
      .i_clk      (clk),
      .i_rst_n    (reset_n),
      .i_run      (run[gi]),
      .i_tick     (r_tick),
      .i_edit_inc (w_edit_inc & w_sel),
      .i_edit_dec (w_edit_dec & w_sel),
      .i_field    (field_sel),
      .o_sec      (w_ch_sec[gi]),
      .o_min      (w_ch_min[gi]),
      .o_hour     (w_ch_hour[gi]),
      .o_done     (done[gi])
    );
  end

  // Unmatched ch_sel (including codes >= N_CH) reads as zero.
  always_comb begin
    sec_out  = '0;
    min_out  = '0;
    hour_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        sec_out  = w_ch_sec[i];
        min_out  = w_ch_min[i];
        hour_out = w_ch_hour[i];
      end
    end
  end

  assign tick = r_tick;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (CLK_FREQ_HZ=4, N_CH=2) with a cycle model
// feeding an expected-value queue.
module tb_timer_bank;

  localparam int F  = 4;
  localparam int NC = 2;
  localparam int W  = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] run;
  logic       ch_sel;
  logic [1:0] field_sel;
  logic       inc;
  logic       dec;
  logic [5:0] sec_out;
  logic [5:0] min_out;
  logic [4:0] hour_out;
  logic [1:0] done;
  logic       tick;

  always #5 clk = ~clk;

  timer_bank #(.CLK_FREQ_HZ(F), .N_CH(NC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .ch_sel    (ch_sel),
    .field_sel (field_sel),
    .inc       (inc),
    .dec       (dec),
    .sec_out   (sec_out),
    .min_out   (min_out),
    .hour_out  (hour_out),
    .done      (done),
    .tick      (tick)
  );

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  // Reference model of the spec, advanced once per clock.
  int m_sec[NC];
  int m_min[NC];
  int m_hour[NC];
  bit m_done[NC];
  int m_preset[NC];
  bit m_tick;
  int m_cnt;
  bit m_inc_prev;
  bit m_dec_prev;

  function automatic logic [W-1:0] obs_vec();
    return {sec_out, min_out, hour_out, done, tick};
  endfunction

  function automatic logic [W-1:0] model_vec();
    int c;
    c = int'(ch_sel);
    return {6'(m_sec[c]), 6'(m_min[c]), 5'(m_hour[c]), m_done[1], m_done[0], m_tick};
  endfunction

  task automatic push_exp(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop(input logic [W-1:0] obs);
    logic [W-1:0] e;
    string        t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic check_model(input string tag);
    push_exp(tag, model_vec());
    check_pop(obs_vec());
  endtask

  task automatic check_field(input string tag, input logic [W-1:0] obs, input logic [W-1:0] e);
    push_exp(tag, e);
    check_pop(obs);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_sec[c] = 0; m_min[c] = 0; m_hour[c] = 0; m_done[c] = 0; m_preset[c] = 0;
    end
    m_tick = 0; m_cnt = 0; m_inc_prev = 0; m_dec_prev = 0;
  endtask

  function automatic int total(input int c);
    return m_hour[c] * 3600 + m_min[c] * 60 + m_sec[c];
  endfunction

  task automatic set_total(input int c, input int t);
    m_hour[c] = t / 3600;
    m_min[c]  = (t / 60) % 60;
    m_sec[c]  = t % 60;
  endtask

  task automatic expire(input int c);
    m_done[c] = 1;
`ifdef TIMER_AUTO_RELOAD_EN
    if (m_preset[c] != 0) set_total(c, m_preset[c]);
`endif
  endtask

  task automatic apply_edit(input int c, input bit up);
    case (field_sel)
      2'b00: m_sec[c]  = (m_sec[c]  + (up ? 1 : 59)) % 60;
      2'b01: m_min[c]  = (m_min[c]  + (up ? 1 : 59)) % 60;
      2'b10: m_hour[c] = (m_hour[c] + (up ? 1 : 23)) % 24;
      default: ;
    endcase
    m_preset[c] = total(c);
  endtask

  // Update the model from the inputs in force, then let one clock edge pass.
  task automatic step();
    bit ri, rd, ei, ed, act;
    ri = inc && !m_inc_prev;
    rd = dec && !m_dec_prev;
    ei = ri && !rd;
    ed = rd && !ri;
    for (int c = 0; c < NC; c++) begin
      if (!run[c]) begin
        m_done[c] = 0;
        if ((ei || ed) && int'(ch_sel) == c && field_sel != 2'b11) apply_edit(c, ei);
      end else begin
        act = !m_done[c];
`ifdef TIMER_AUTO_RELOAD_EN
        if (m_preset[c] != 0) begin
          act = 1;
          m_done[c] = 0;
        end
`endif
        if (act) begin
          if (total(c) == 0) expire(c);
          else if (m_tick) begin
            set_total(c, total(c) - 1);
            if (total(c) == 0) expire(c);
          end
        end
      end
    end
    m_tick     = (m_cnt == F - 1);
    m_cnt      = (m_cnt + 1) % F;
    m_inc_prev = inc;
    m_dec_prev = dec;
    @(negedge clk);
  endtask

  task automatic pulse(input bit do_inc, input bit do_dec);
    inc = do_inc;
    dec = do_dec;
    step();
    inc = 1'b0;
    dec = 1'b0;
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    run       = '0;
    ch_sel    = 1'b0;
    field_sel = 2'b00;
    inc       = 1'b0;
    dec       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_field("reset_state", obs_vec(), '0);
    reset_n = 1'b1;

    // Idle: tick after edges 4, 8, 12 and everything else zero.
    for (int k = 1; k <= 12; k++) begin
      step();
      check_field($sformatf("idle_tick_%0d", k), obs_vec(), W'((k % F) == 0));
    end

    // Field wraps on stopped channel 1.
    ch_sel = 1'b1;
    field_sel = 2'b00;
    pulse(1'b0, 1'b1);
    check_field("sec_dec_wrap", W'(sec_out), W'(59));
    check_model("sec_dec_wrap_m");
    pulse(1'b1, 1'b0);
    check_field("sec_inc_wrap", W'({sec_out, min_out}), W'(0));
    check_model("sec_inc_wrap_m");
    pulse(1'b0, 1'b1);
    check_field("sec_dec_again", W'(sec_out), W'(59));
    field_sel = 2'b01;
    pulse(1'b0, 1'b1);
    check_field("min_dec_wrap", W'({sec_out, min_out}), W'({6'd59, 6'd59}));
    pulse(1'b1, 1'b0);
    check_field("min_inc_wrap", W'(min_out), W'(0));
    field_sel = 2'b10;
    pulse(1'b0, 1'b1);
    check_field("hour_dec_wrap", W'(hour_out), W'(23));
    pulse(1'b1, 1'b0);
    check_field("hour_inc_wrap", W'(hour_out), W'(0));
    check_model("ch1_edits_m");
    field_sel = 2'b11;
    pulse(1'b1, 1'b0);
    check_model("field_none_noop");
    field_sel = 2'b00;
    pulse(1'b1, 1'b1);
    check_field("inc_dec_cancel", W'({sec_out, min_out, hour_out}), W'({6'd59, 6'd0, 5'd0}));

    // Channel 0 counts down from 00:01:00; edits while running are dropped.
    ch_sel = 1'b0;
    field_sel = 2'b01;
    pulse(1'b1, 1'b0);
    check_field("ch0_load", W'({sec_out, min_out, hour_out}), W'({6'd0, 6'd1, 5'd0}));
    run = 2'b01;
    field_sel = 2'b00;
    pulse(1'b1, 1'b0);
    check_model("inc_while_run");
    for (int k = 0; k < 248; k++) begin
      step();
      check_model($sformatf("countdown_%0d", k));
    end
    check_field("ch0_expired_val", W'({sec_out, min_out, hour_out}), W'(0));
    check_field("ch0_done", W'(done), W'(2'b01));
    ch_sel = 1'b1;
    #1;
    check_field("ch1_untouched", W'({sec_out, min_out, hour_out}), W'({6'd59, 6'd0, 5'd0}));
    run = 2'b00;
    step();
    check_field("done_clear", W'(done), W'(0));
    check_model("done_clear_m");

    // Asynchronous reset in the middle of a count.
    ch_sel = 1'b0;
    field_sel = 2'b10;
    pulse(1'b1, 1'b0);
    check_field("ch0_hour_load", W'({sec_out, min_out, hour_out}), W'({6'd0, 6'd0, 5'd1}));
    run = 2'b01;
    for (int k = 0; k < 9; k++) begin
      step();
      check_model($sformatf("hour_run_%0d", k));
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_field("async_reset", obs_vec(), '0);
    run = 2'b00;
    model_reset();
    @(negedge clk);
    check_field("held_reset", obs_vec(), '0);
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_field($sformatf("post_reset_%0d", k), obs_vec(), W'((k % F) == 0));
    end

`ifdef TIMER_AUTO_RELOAD_EN
    field_sel = 2'b00;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check_field("preset_load", W'(sec_out), W'(2));
    run = 2'b01;
    for (int k = 0; k < 40; k++) begin
      step();
      check_model($sformatf("reload_%0d", k));
    end
    run = 2'b00;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
